fpu_op_sequencer: RTL and testbench

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

---
 rtl/fpu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_fpu_op_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer.sv
// Sequences single-precision commands through an external combinational FPU:
// registers operands, waits one settle cycle, captures result/flags and holds them until consumed.
module fpu_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_oper,
  output logic [31:0] alu_input1,
  output logic [31:0] alu_input2,
  output logic [1:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  input  logic        alu_exception,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [1:0]  out_oper,
  output logic [2:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic [15:0] op_count,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_alu_input1;
  logic [31:0] r_alu_input2;
  logic [1:0]  r_alu_oper;
  logic [31:0] r_out_result;
  logic [2:0]  r_out_flags;
  logic [1:0]  r_out_oper;
  logic [2:0]  r_sticky_flags;
  logic [15:0] r_op_count;
  logic        r_out_valid;
  logic        r_busy;

  logic        w_accept;
  logic        w_capture;
  logic [2:0]  w_alu_flags;

  // A held result frees the slot in the same cycle it is consumed.
  assign in_ready    = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_capture   = (r_state == StExec);
  assign w_alu_flags = {alu_overflow, alu_underflow, alu_exception};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_alu_input1   <= 32'h0000_0000;
      r_alu_input2   <= 32'h0000_0000;
      r_alu_oper     <= 2'b00;
      r_out_result   <= 32'h0000_0000;
      r_out_flags    <= 3'b000;
      r_out_oper     <= 2'b00;
      r_sticky_flags <= 3'b000;
      r_op_count     <= 16'h0000;
      r_out_valid    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_input1 <= in_a;
        r_alu_input2 <= in_b;
        r_alu_oper   <= in_oper;
      end
      if (w_capture) begin
        r_out_result <= alu_result;
        r_out_flags  <= w_alu_flags;
        r_out_oper   <= r_alu_oper;
        r_op_count   <= r_op_count + 16'd1;
      end
      // Flags captured this cycle survive a coincident clear.
      r_sticky_flags <= (sticky_clr ? 3'b000 : r_sticky_flags) |
                        (w_capture ? w_alu_flags : 3'b000);

      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StExec;
            r_busy  <= 1'b1;
          end
        end
        StExec: begin
          r_state     <= StDone;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b1;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_state <= StExec;
              r_busy  <= 1'b1;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign alu_input1   = r_alu_input1;
  assign alu_input2   = r_alu_input2;
  assign alu_oper     = r_alu_oper;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_flags    = r_out_flags;
  assign out_oper     = r_out_oper;
  assign sticky_flags = r_sticky_flags;
  assign op_count     = r_op_count;
  assign busy         = r_busy;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: behavioural FP ALU on the alu_* ports, transaction-level model,
// directed scenarios followed by randomized handshakes.
module tb_fpu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, sticky_clr, busy;
  logic [31:0] in_a, in_b, alu_input1, alu_input2, alu_result, out_result;
  logic [1:0]  in_oper, alu_oper, out_oper;
  logic        alu_overflow, alu_underflow, alu_exception;
  logic [2:0]  out_flags, sticky_flags;
  logic [15:0] op_count;
  logic [34:0] alu_bus;

  int n_checks = 0;
  int n_fails  = 0;

  fpu_op_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_oper      (in_oper),
    .alu_input1   (alu_input1),
    .alu_input2   (alu_input2),
    .alu_oper     (alu_oper),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_underflow(alu_underflow),
    .alu_exception(alu_exception),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_oper     (out_oper),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .op_count     (op_count),
    .busy         (busy)
  );

  // Behavioural single-precision ALU (denormals flushed, results truncated).
  function automatic real fp_to_real(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [34:0] real_to_fp(input real r);
    logic        s;
    real         m;
    int          e;
    logic [22:0] f;
    s = (r < 0.0);
    m = s ? -r : r;
    if (m == 0.0) return {3'b000, s, 31'd0};
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e > 127) return {3'b100, s, 8'hFF, 23'd0};
    if (e < -126) return {3'b010, s, 31'd0};
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {3'b000, s, 8'(e + 127), f};
  endfunction

  // Returns {overflow, underflow, exception, result}.
  function automatic logic [34:0] fp_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    real ra, rb, r;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b001, 32'h7FC0_0000};
    ra = fp_to_real(a);
    rb = fp_to_real(b);
    case (op)
      2'b00:   r = ra + rb;
      2'b01:   r = ra - rb;
      2'b10:   r = ra * rb;
      default: begin
        if (rb == 0.0) return {3'b001, a[31] ^ b[31], 8'hFF, 23'd0};
        r = ra / rb;
      end
    endcase
    return real_to_fp(r);
  endfunction

  always_comb alu_bus = fp_alu(alu_input1, alu_input2, alu_oper);
  assign alu_result    = alu_bus[31:0];
  assign alu_overflow  = alu_bus[34];
  assign alu_underflow = alu_bus[33];
  assign alu_exception = alu_bus[32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction model: m_age counts edges since the accept of the live command.
  logic        m_live;
  int          m_age;
  logic [31:0] m_alu1, m_alu2, m_res;
  logic [1:0]  m_aop, m_oop;
  logic [2:0]  m_flags, m_sticky;
  logic [15:0] m_count;
  int          cyc = 0;
  logic [31:0] got_q[$];
  int          got_cyc_q[$];

  task automatic model_reset();
    m_live = 1'b0; m_age = 0; m_alu1 = '0; m_alu2 = '0; m_aop = '0;
    m_res = '0; m_flags = '0; m_oop = '0; m_sticky = '0; m_count = '0;
  endtask

  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic ordy, input logic clr,
                       input logic r);
    logic        exp_rdy, acc, cap;
    logic [34:0] alu_m;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_oper = op;
    out_ready = ordy; sticky_clr = clr; rst = r;
    #1;
    exp_rdy = !m_live || (m_age >= 2 && ordy);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(m_live && m_age >= 2));
    check_eq("busy", 32'(busy), 32'(m_live));
    check_eq("alu_input1", alu_input1, m_alu1);
    check_eq("alu_input2", alu_input2, m_alu2);
    check_eq("alu_oper", 32'(alu_oper), 32'(m_aop));
    check_eq("out_result", out_result, m_res);
    check_eq("out_flags", 32'(out_flags), 32'(m_flags));
    check_eq("out_oper", 32'(out_oper), 32'(m_oop));
    check_eq("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
    check_eq("op_count", 32'(op_count), 32'(m_count));
    if (out_valid && ordy) begin
      got_q.push_back(out_result);
      got_cyc_q.push_back(cyc);
    end
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      cap = m_live && (m_age == 1);
      acc = v && exp_rdy;
      if (cap) begin
        alu_m   = fp_alu(m_alu1, m_alu2, m_aop);
        m_res   = alu_m[31:0];
        m_flags = alu_m[34:32];
        m_oop   = m_aop;
        m_count = m_count + 16'd1;
      end
      m_sticky = (clr ? 3'b000 : m_sticky) | (cap ? m_flags : 3'b000);
      if (acc) begin
        m_live = 1'b1; m_age = 1; m_alu1 = a; m_alu2 = b; m_aop = op;
      end else if (m_live) begin
        if (m_age >= 2 && ordy) m_live = 1'b0;
        else if (m_age == 1) m_age = 2;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'd0, 32'd0, 2'b00, ordy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(110, 144));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  logic [31:0] b2b_a[4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000};
  logic [31:0] b2b_b[4] = '{32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000};
  logic [1:0]  b2b_o[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [31:0] b2b_r[4] = '{32'h4000_0000, 32'h40C0_0000, 32'h4040_0000, 32'h4080_0000};

  initial begin
    int idx;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_oper = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_op_count", 32'(op_count), 32'd0);

    // Add with fixed latency
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("add_valid_early", 32'(out_valid), 32'd0);
    idle(1'b0);
    check_eq("add_valid", 32'(out_valid), 32'd1);
    check_eq("add_result", out_result, 32'h4040_0000);
    check_eq("add_flags", 32'(out_flags), 32'd0);
    check_eq("add_count", 32'(op_count), 32'd1);
    idle(1'b1);

    // Multiply held under backpressure; in_valid during DONE is ignored
    cycle(1'b1, 32'h4000_0000, 32'h4040_0000, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rand_fp(), rand_fp(), 2'($urandom), 1'b0, 1'b0, 1'b0);
      check_eq("mul_hold_result", out_result, 32'h40C0_0000);
      check_eq("mul_hold_ready", 32'(in_ready), 32'd0);
    end
    idle(1'b1);
    idle(1'b0);
    check_eq("mul_done", 32'(out_valid), 32'd0);
    check_eq("mul_oper", 32'(out_oper), 32'd2);

    // Divide by zero, then a clean add, then a clear
    cycle(1'b1, 32'h3F80_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check_eq("div0_exc", 32'(out_flags[0]), 32'd1);
    check_eq("div0_sticky", 32'(sticky_flags), 32'd1);
    cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check_eq("clean_sticky", 32'(sticky_flags), 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("clr_sticky", 32'(sticky_flags), 32'd0);

    // Back-to-back stream of four commands
    cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    got_q.delete();
    got_cyc_q.delete();
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      if (idx < 4) begin
        cycle(1'b1, b2b_a[idx], b2b_b[idx], b2b_o[idx], 1'b1, 1'b0, 1'b0);
        if (!m_live || m_age == 1) idx++;
      end else begin
        idle(1'b1);
      end
    end
    check_eq("b2b_count", 32'(op_count), 32'd4);
    check_eq("b2b_n_results", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("b2b_result", (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, b2b_r[i]);
    for (int i = 0; i < 3; i++)
      check_eq("b2b_gap", (i + 1 < got_cyc_q.size()) ?
               32'(got_cyc_q[i + 1] - got_cyc_q[i]) : 32'hFFFF_FFFF, 32'd2);

    // Reset while the command sits in EXEC
    cycle(1'b1, 32'h4000_0000, 32'h4000_0000, 2'b10, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("rstx_valid", 32'(out_valid), 32'd0);
    check_eq("rstx_count", 32'(op_count), 32'd0);
    check_eq("rstx_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    check_eq("rstx_no_capture", 32'(out_valid), 32'd0);

    // Counter wrap
    force dut.r_op_count = 16'hFFFE;
    #1;
    release dut.r_op_count;
    m_count = 16'hFFFE;
    cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check_eq("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
    cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    check_eq("wrap_zero", 32'(op_count), 32'd0);

    // Clear coincident with an exception capture
    cycle(1'b1, 32'h3F80_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("clr_cap_sticky", 32'(sticky_flags), 32'd1);
    idle(1'b1);

    // Randomized handshakes, clears and resets
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_fp(), rand_fp(), 2'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
